// File: rtl/ring_sequencer.sv
// ring_sequencer
// Cadence controller for the tone generator. Produces the gated enable that
// makes the ringer emit timed tone bursts separated by silent gaps. A caller
// requests N bursts (1..15), or continuous ringing (bursts=0) until stopped.
//
// Ports:
//   clk        in   system clock, rising-edge logic
//   reset_n    in   synchronous active-low reset
//   start      in   begin a sequence (only honoured in IDLE)
//   stop       in   abort the current sequence (priority over start)
//   bursts     in   burst count latched on an accepted start, 0 = continuous
//   ring_on    out  connects to the ringer's on input, high during bursts
//   busy       out  high while a sequence is active (ON or OFF)
//   remaining  out  bursts left including the current one, 0 when continuous/IDLE
//   done       out  one-cycle pulse on natural completion of a counted sequence
module ring_sequencer #(
    parameter int ON_CYCLES  = 10_000_000,
    parameter int OFF_CYCLES = 15_000_000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       stop,
    input  logic [3:0] bursts,
    output logic       ring_on,
    output logic       busy,
    output logic [3:0] remaining,
    output logic       done
);

    localparam int MAX_CYCLES = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_CYCLES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ON   = 2'd1;
    localparam logic [1:0] S_OFF  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       rem_q, rem_d;
    logic             cont_q, cont_d;
    logic             ring_on_q, ring_on_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        rem_d   = rem_q;
        cont_d  = cont_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start && !stop) begin
                    state_d = S_ON;
                    rem_d   = bursts;
                    cont_d  = (bursts == 4'd0);
                end
            end
            S_ON: begin
                if (cnt_q == ON_LAST) begin
                    cnt_d = '0;
                    if (cont_q) begin
                        state_d = S_OFF;
                    end else if (rem_q > 4'd1) begin
                        state_d = S_OFF;
                        rem_d   = rem_q - 4'd1;
                    end else begin
                        // Last burst ends straight into IDLE: no trailing gap.
                        state_d = S_IDLE;
                        rem_d   = 4'd0;
                        cont_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            S_OFF: begin
                if (cnt_q == OFF_LAST) begin
                    cnt_d   = '0;
                    state_d = S_ON;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                rem_d   = 4'd0;
                cont_d  = 1'b0;
            end
        endcase

        // Abort wins over everything, including a same-cycle terminal count,
        // so a stopped sequence never reports done.
        if (stop && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            rem_d   = 4'd0;
            cont_d  = 1'b0;
            done_d  = 1'b0;
        end

        // Outputs are registered from the next state so they line up with it.
        ring_on_d = (state_d == S_ON);
        busy_d    = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            rem_q     <= 4'd0;
            cont_q    <= 1'b0;
            ring_on_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            cont_q    <= cont_d;
            ring_on_q <= ring_on_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign ring_on   = ring_on_q;
    assign busy      = busy_q;
    assign remaining = rem_q;
    assign done      = done_q;

endmodule

// File: tb/tb_ring_sequencer.sv
module tb_ring_sequencer;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic       stop;
    logic [3:0] bursts;
    logic       ring_on;
    logic       busy;
    logic [3:0] remaining;
    logic       done;

    int n_cmp;
    int n_bad;

    ring_sequencer #(
        .ON_CYCLES (4),
        .OFF_CYCLES(3)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .stop     (stop),
        .bursts   (bursts),
        .ring_on  (ring_on),
        .busy     (busy),
        .remaining(remaining),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle; values seen afterwards belong to the next cycle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_outs(input string tag, input int c, input logic er,
                               input logic eb, input logic [3:0] erem, input logic ed);
        chk($sformatf("%s c%0d ring_on", tag, c), {3'b000, ring_on}, {3'b000, er});
        chk($sformatf("%s c%0d busy", tag, c), {3'b000, busy}, {3'b000, eb});
        chk($sformatf("%s c%0d remaining", tag, c), remaining, erem);
        chk($sformatf("%s c%0d done", tag, c), {3'b000, done}, {3'b000, ed});
    endtask

    initial begin
        logic       er, eb, ed;
        logic [3:0] erem;
        n_cmp   = 0;
        n_bad   = 0;
        reset_n = 1'b0;
        start   = 1'b1;
        stop    = 1'b0;
        bursts  = 4'd2;

        // Reset held for 3 edges with start asserted.
        for (int i = 0; i < 3; i++) begin
            step();
            expect_outs("reset", i, 1'b0, 1'b0, 4'd0, 1'b0);
        end

        // Release reset with start still high and bursts=2: accepted on first edge.
        // Done at cycle 12, and a back-to-back bursts=1 start in that cycle.
        reset_n = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            step();
            er   = (c <= 4) || (c >= 8 && c <= 11) || (c >= 13 && c <= 16);
            eb   = (c <= 11) || (c >= 13 && c <= 16);
            erem = (c <= 4) ? 4'd2 : (c <= 11) ? 4'd1 : (c == 12) ? 4'd0 :
                   (c <= 16) ? 4'd1 : 4'd0;
            ed   = (c == 12) || (c == 17);
            expect_outs("b2", c, er, eb, erem, ed);
            if (c == 1) start = 1'b0;
            if (c == 12) begin
                start  = 1'b1;
                bursts = 4'd1;
            end
            if (c == 13) start = 1'b0;
        end

        // Continuous mode, stop sampled at the end of cycle 20.
        start  = 1'b1;
        bursts = 4'd0;
        for (int c = 1; c <= 25; c++) begin
            step();
            if (c <= 20) expect_outs("cont", c, ((c - 1) % 7) < 4, 1'b1, 4'd0, 1'b0);
            else         expect_outs("cont", c, 1'b0, 1'b0, 4'd0, 1'b0);
            if (c == 1) start = 1'b0;
            if (c == 20) stop = 1'b1;
            if (c == 21) stop = 1'b0;
        end

        // Single burst, no trailing gap, never re-asserts.
        start  = 1'b1;
        bursts = 4'd1;
        for (int c = 1; c <= 10; c++) begin
            step();
            expect_outs("b1", c, c <= 4, c <= 4, (c <= 4) ? 4'd1 : 4'd0, c == 5);
            if (c == 1) start = 1'b0;
        end

        // bursts=3 with stray start pulses in cycles 2 and 6 (and a new bursts value).
        start  = 1'b1;
        bursts = 4'd3;
        for (int c = 1; c <= 21; c++) begin
            step();
            er   = (c <= 4) || (c >= 8 && c <= 11) || (c >= 15 && c <= 18);
            erem = (c <= 4) ? 4'd3 : (c <= 11) ? 4'd2 : (c <= 18) ? 4'd1 : 4'd0;
            expect_outs("b3", c, er, c <= 18, erem, c == 19);
            start = (c == 2) || (c == 6);
            if (c == 1) bursts = 4'd5;
        end
        start = 1'b0;

        // start and stop together in IDLE: stays IDLE.
        start  = 1'b1;
        stop   = 1'b1;
        bursts = 4'd2;
        for (int c = 1; c <= 3; c++) begin
            step();
            expect_outs("ss_idle", c, 1'b0, 1'b0, 4'd0, 1'b0);
        end
        start = 1'b0;
        stop  = 1'b0;

        // stop coincident with the last ON count of a single-burst sequence.
        start  = 1'b1;
        bursts = 4'd1;
        for (int c = 1; c <= 7; c++) begin
            step();
            expect_outs("stop_last", c, c <= 4, c <= 4, (c <= 4) ? 4'd1 : 4'd0, 1'b0);
            if (c == 1) start = 1'b0;
            stop = (c == 4);
        end
        stop = 1'b0;

        // Mid-operation reset at cycle 6 of a bursts=3 sequence, then fresh bursts=1.
        start  = 1'b1;
        bursts = 4'd3;
        for (int c = 1; c <= 7; c++) begin
            step();
            if (c <= 4)      expect_outs("mid_rst", c, 1'b1, 1'b1, 4'd3, 1'b0);
            else if (c <= 6) expect_outs("mid_rst", c, 1'b0, 1'b1, 4'd2, 1'b0);
            else             expect_outs("mid_rst", c, 1'b0, 1'b0, 4'd0, 1'b0);
            if (c == 1) start = 1'b0;
            if (c == 6) reset_n = 1'b0;
            if (c == 7) begin
                reset_n = 1'b1;
                start   = 1'b1;
                bursts  = 4'd1;
            end
        end
        for (int c = 1; c <= 9; c++) begin
            step();
            expect_outs("post_rst", c, c <= 4, c <= 4, (c <= 4) ? 4'd1 : 4'd0, c == 5);
            if (c == 1) start = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
